// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts rising edges of an asynchronous
// ro_in over a programmable gate window of clk cycles and reports the result.
module ro_freq_counter #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ro_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic [CNT_W-1:0]  count,
  output logic              valid,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [GATE_W-1:0] GATE_ZERO  = {GATE_W{1'b0}};
  localparam logic [GATE_W-1:0] TIMER_LAST = GATE_W'(1);

  state_t              state_r;
  state_t              state_s;
  logic                sync1_r;
  logic                sync2_r;
  logic                hist_r;
  logic                edge_s;
  logic [GATE_W-1:0]   timer_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                ovf_flag_r;
  logic                ovf_nxt_s;
  logic [CNT_W-1:0]    count_r;
  logic                ovf_r;
  logic                valid_s;
  logic                busy_s;

  assign edge_s = sync2_r & ~hist_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (gate_len == GATE_ZERO) ? DONE : GATE;
        end else begin
          state_s = IDLE;
        end
      end
      GATE: begin
        if (timer_r == TIMER_LAST) begin
          state_s = DONE;
        end else begin
          state_s = GATE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    valid_s = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      IDLE: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      GATE: begin
        valid_s = 1'b0;
        busy_s  = 1'b1;
      end
      DONE: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Saturating edge counter; once saturated, any further edge marks overflow
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = ovf_flag_r;
    if (state_r == GATE && edge_s) begin
      if (cnt_r == CNT_MAX) begin
        ovf_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
      ovf_nxt_s = ovf_flag_r;
    end
  end

  // Synchronizer and edge-history flops, running in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      hist_r  <= 1'b0;
    end else begin
      sync1_r <= ro_in;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  // Gate timer, edge counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r    <= GATE_ZERO;
      cnt_r      <= CNT_ZERO;
      ovf_flag_r <= 1'b0;
      count_r    <= CNT_ZERO;
      ovf_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            timer_r    <= gate_len;
            cnt_r      <= CNT_ZERO;
            ovf_flag_r <= 1'b0;
            // A zero-length window completes immediately with an empty result
            if (gate_len == GATE_ZERO) begin
              count_r <= CNT_ZERO;
              ovf_r   <= 1'b0;
            end
          end
        end
        GATE: begin
          timer_r    <= timer_r - TIMER_LAST;
          cnt_r      <= cnt_nxt_s;
          ovf_flag_r <= ovf_nxt_s;
          // Result includes an edge detected in the final gate cycle
          if (timer_r == TIMER_LAST) begin
            count_r <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
          end
        end
        DONE: begin
          timer_r <= timer_r;
        end
        default: begin
          timer_r <= GATE_ZERO;
        end
      endcase
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;
  assign valid = valid_s;
  assign busy  = busy_s;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter: a 16-bit and a 4-bit counter share
// the same stimulus; a monitor checks every valid pulse against the queue.
module tb_ro_freq_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ro_in;
  logic        start;
  logic [15:0] gate_len;
  logic [15:0] count;
  logic        valid, busy, ovf;
  logic [3:0]  count4;
  logic        valid4, busy4, ovf4;

  typedef struct {
    int c16;
    int o16;
    int c4;
    int o4;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  int   ro_en  = 0;
  int   ro_t0  = 0;
  int   ro_per = 10;
  logic ro_lvl = 1'b0;
  int   s;

  ro_freq_counter #(.CNT_W(16), .GATE_W(16)) dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .gate_len(gate_len),
    .count(count), .valid(valid), .busy(busy), .ovf(ovf)
  );

  ro_freq_counter #(.CNT_W(4), .GATE_W(16)) dut4 (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .gate_len(gate_len),
    .count(count4), .valid(valid4), .busy(busy4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; drive ro_in from the active pattern just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (ro_en != 0 && cyc >= ro_t0 && ((cyc - ro_t0) % ro_per) < (ro_per / 2))
      ro_in = 1'b1;
    else
      ro_in = ro_lvl;
  endtask

  // Issue start for one cycle and queue the expected result; returns sample edge.
  task automatic start_meas(input int g, input int e16, input int o16,
                            input int e4, input int o4, output int s_out);
    exp_t e;
    gate_len = g[15:0];
    start    = 1'b1;
    s_out    = cyc + 1;
    e.c16 = e16; e.o16 = o16; e.c4 = e4; e.o4 = o4; e.at = s_out + g;
    sb.push_back(e);
    step();
    start = 1'b0;
  endtask

  // Count cycles with busy high until it drops (bounded).
  task automatic wait_idle(input string name, input int exp_busy);
    int bcnt;
    bcnt = 0;
    for (int i = 0; i < 400 && busy; i++) begin
      bcnt++;
      step();
    end
    chk(name, bcnt, exp_busy);
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (valid || valid4) begin
        chk("valid_pair", valid4, valid);
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("valid_cycle", cyc, mon_e.at);
          chk("count16", count, mon_e.c16);
          chk("ovf16", ovf, mon_e.o16);
          chk("count4", count4, mon_e.c4);
          chk("ovf4", ovf4, mon_e.o4);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ro_in = 1'b0; start = 1'b0; gate_len = 16'd0;
    step(); step(); step();
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    step(); step();

    // Period-10 oscillator, first rise 5 cycles after start, 100-cycle gate
    start_meas(100, 10, 0, 10, 0, s);
    ro_en = 1; ro_per = 10; ro_t0 = s + 5;
    wait_idle("busy_g100", 101);
    ro_en = 0; ro_lvl = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("hold_count", count, 10);
    chk("hold_ovf", ovf, 0);

    // Constant-high oscillator yields no edges
    ro_lvl = 1'b1;
    for (int i = 0; i < 5; i++) step();
    start_meas(50, 0, 0, 0, 0, s);
    wait_idle("busy_g50", 51);
    ro_lvl = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Zero-length gate
    start_meas(0, 0, 0, 0, 0, s);
    wait_idle("busy_g0", 1);
    step(); step();

    // Period-4 oscillator: 25 edges saturate the 4-bit counter
    start_meas(100, 25, 0, 15, 1, s);
    ro_en = 1; ro_per = 4; ro_t0 = s + 1;
    wait_idle("busy_sat", 101);
    ro_en = 0; ro_lvl = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Start during gate is ignored, then back-to-back start in the next IDLE
    start_meas(100, 10, 0, 10, 0, s);
    ro_en = 1; ro_per = 10; ro_t0 = s + 5;
    for (int i = 0; i < 20; i++) step();
    gate_len = 16'd5;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_idle("busy_ignored_start", 80);
    chk("idle_after_done", cyc, s + 101);
    ro_en = 0; ro_lvl = 1'b0;
    start_meas(3, 0, 0, 0, 0, s);
    wait_idle("busy_b2b", 4);
    for (int i = 0; i < 5; i++) step();

    // Reset mid-gate abandons the measurement
    start_meas(100, 10, 0, 10, 0, s);
    ro_en = 1; ro_per = 10; ro_t0 = s + 5;
    for (int i = 0; i < 40; i++) step();
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_ovf", ovf, 0);
    void'(sb.pop_back());
    step();
    rst = 1'b0;
    ro_en = 0; ro_lvl = 1'b0;
    for (int i = 0; i < 120; i++) step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", count, 0);

    start_meas(100, 10, 0, 10, 0, s);
    ro_en = 1; ro_per = 10; ro_t0 = s + 5;
    wait_idle("busy_after_rst", 101);
    ro_en = 0; ro_lvl = 1'b0;
    for (int i = 0; i < 5; i++) step();

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
